// File: rtl/divisor_4bits.sv
// divisor_4bits: unsigned 4-bit restoring divider, one quotient bit per cycle.
// Ports: clk/rst (async active-high) clock and reset; start requests a division;
// ina_3..0 dividend A, inb_3..0 divisor B (MSB first);
// outq_3..0 quotient, outr_3..0 remainder, held from DONE until the next result;
// busy high in CALC, done one-cycle pulse in DONE, div_zero set when B was 0.
module divisor_4bits (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic ina_3,
  input  logic ina_2,
  input  logic ina_1,
  input  logic ina_0,
  input  logic inb_3,
  input  logic inb_2,
  input  logic inb_1,
  input  logic inb_0,
  output logic outq_3,
  output logic outq_2,
  output logic outq_1,
  output logic outq_0,
  output logic outr_3,
  output logic outr_2,
  output logic outr_1,
  output logic outr_0,
  output logic busy,
  output logic done,
  output logic div_zero
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic start_q, accept, cout, dz_q, dz_d;
  logic [3:0] a, b, b_q, b_d, rem_q, rem_d, quo_q, quo_d, rem_nx, quo_nx;
  logic [3:0] outq_q, outq_d, outr_q, outr_d;
  logic [1:0] cnt_q, cnt_d;
  logic [4:0] sh_rem, diff;
  assign a = {ina_3, ina_2, ina_1, ina_0};
  assign b = {inb_3, inb_2, inb_1, inb_0};
  // start is registered, giving the one-edge acceptance delay behind the
  // 5-cycle (B != 0) and 1-cycle (B = 0) latencies; operands are captured
  // from the live inputs on the accepting edge.
  assign accept = start_q && state_q != CALC;
  assign sh_rem = {rem_q, quo_q[3]};
  // carry-out set means no borrow, i.e. the shifted remainder is >= B
  assign {cout, diff} = {1'b0, sh_rem} + {2'b01, ~b_q} + 6'd1;
  assign rem_nx = 4'(cout ? diff : sh_rem);
  assign quo_nx = {quo_q[2:0], cout};
  always_comb begin
    state_d = state_q;
    b_d = b_q;
    rem_d = rem_q;
    quo_d = quo_q;
    cnt_d = cnt_q;
    outq_d = outq_q;
    outr_d = outr_q;
    dz_d = dz_q;
    if (accept) begin
      b_d = b;
      rem_d = '0;
      quo_d = a;
      cnt_d = '0;
      state_d = (b == '0) ? DONE : CALC;
      if (b == '0) begin
        outq_d = 4'hF;
        outr_d = a;
        dz_d = 1'b1;
      end
    end else if (state_q == CALC) begin
      rem_d = rem_nx;
      quo_d = quo_nx;
      cnt_d = cnt_q + 2'd1;
      if (cnt_q == 2'd3) begin
        state_d = DONE;
        outq_d = quo_nx;
        outr_d = rem_nx;
        dz_d = 1'b0;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      b_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      outq_q <= '0;
      outr_q <= '0;
      dz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      b_q <= b_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
      outq_q <= outq_d;
      outr_q <= outr_d;
      dz_q <= dz_d;
    end
  end
  assign {outq_3, outq_2, outq_1, outq_0} = outq_q;
  assign {outr_3, outr_2, outr_1, outr_0} = outr_q;
  assign busy = state_q == CALC;
  assign done = state_q == DONE;
  assign div_zero = dz_q;
endmodule

// File: doc/divisor_4bits.md
DIVISOR_4BITS -- requirements
Module: divisor_4bits

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: request a division; sampled on the rising edge of clk.
REQ-004 SHALL have ports ina_3..ina_0, input, 1 bit each: dividend A, with ina_3 as the MSB.
REQ-005 SHALL have ports inb_3..inb_0, input, 1 bit each: divisor B, with inb_3 as the MSB.
REQ-006 SHALL have ports outq_3..outq_0, output, 1 bit each: quotient Q, with outq_3 as the MSB.
REQ-007 SHALL have ports outr_3..outr_0, output, 1 bit each: remainder R, with outr_3 as the MSB.
REQ-008 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse marking that the result is valid.
REQ-010 SHALL have port div_zero, output, 1 bit: high when the last accepted operation had B = 0.

Function
REQ-011 SHALL implement an unsigned 4-bit restoring divider with the FSM states IDLE, CALC and DONE.
REQ-012 SHALL accept start only in IDLE or DONE; on acceptance, SHALL latch A and B, clear the partial remainder register to 0, load the quotient shift register with A, clear the iteration counter, and enter CALC.
REQ-013 SHALL ignore start while in CALC, leaving the latched operands and the in-flight operation unaffected.
REQ-014 SHALL, in each CALC cycle, shift {remainder, quotient} left by 1 bit.
REQ-015 SHALL then form trial = remainder − B as a 5-bit two's-complement add (B inverted, carry-in 1), matching the team's adder/subtractor datapath.
REQ-016 SHALL, when the trial carry-out is 1 (no borrow), write the trial result into the remainder and set quotient bit 0 to 1; otherwise SHALL keep the remainder and set quotient bit 0 to 0.
REQ-017 SHALL perform exactly 4 CALC iterations; the 2-bit counter SHALL wrap from 3 to 0 on the transition to DONE.
REQ-018 SHALL, when B = 0 at acceptance, skip CALC, go directly to DONE, and produce Q = 4'b1111, R = A and div_zero = 1.
REQ-019 SHALL, for a nonzero divisor, give a latency of 5 cycles: start sampled at edge k, done high during the cycle following edge k+5.
REQ-020 SHALL, for B = 0, give a latency of 1 cycle: done high during the cycle following edge k+1.
REQ-021 SHALL update outq, outr and div_zero only on entry to DONE, and SHALL hold them stable until the next entry to DONE or until reset.
REQ-022 SHALL assert busy in CALC only, and done in DONE only; done SHALL last exactly one cycle.
REQ-023 SHALL move from DONE to IDLE when start = 0, and SHALL re-enter CALC (or DONE when B = 0) when start = 1, allowing back-to-back operations.
REQ-024 SHALL guarantee that R < B and A = Q·B + R for every B ≠ 0.

Reset
REQ-025 SHALL, while rst = 1, immediately force the state to IDLE and drive outq = 0, outr = 0, busy = 0, done = 0, div_zero = 0, and clear the internal registers, independent of clk.
REQ-026 SHALL abandon any operation interrupted by reset mid-CALC, produce no done pulse for it, and accept start on the first clock edge after rst deasserts.

Verification
REQ-027 SHALL pass this scenario: A = 13, B = 4, start for 1 cycle -> busy high for 4 cycles, then done with Q = 3, R = 1, div_zero = 0.
REQ-028 SHALL pass this scenario: A = 15, B = 1 -> Q = 15, R = 0; then A = 3, B = 9 -> Q = 0, R = 3.
REQ-029 SHALL pass this scenario: A = 7, B = 0 -> done 1 cycle after start, with Q = 15, R = 7, div_zero = 1.
REQ-030 SHALL pass this scenario: A = 13, B = 4 started, then start with A = 2, B = 1 pulsed during CALC -> the second request is ignored and the result is Q = 3, R = 1.
REQ-031 SHALL pass this scenario: rst asserted in the 2nd CALC cycle -> all outputs 0 immediately, no done pulse, and a new start after release divides correctly.
REQ-032 SHALL pass this scenario: exhaustive 256 (A, B) pairs issued back-to-back (start held high through DONE) -> every result matches a reference model, and done pulses exactly once per operation.
